// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Signed variants are MULT and DIV: op[2] clear and op[0] clear.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider on a
// 2*WIDTH working register {upper, lower}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    acc_next = '0;
    if (!is_div) begin
      // Multiplier sits in the lower half and is consumed LSB first.
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural HI/LO
// registers, with accept handshake, done pulse and in-flight flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    sgn   = op_is_signed(op);
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    prod  = neg_q ? -acc : acc;
    quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            unique case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state  <= CALC;
                cnt    <= '0;
                is_div <= op[1];
                if (op[1]) begin
                  acc  <= {{WIDTH{1'b0}}, a_mag};
                  opnd <= b_mag;
                end else begin
                  acc  <= {{WIDTH{1'b0}}, b_mag};
                  opnd <= a_mag;
                end
                // A zero divisor keeps the quotient unnegated so LO reads all ones.
                neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op[1] || (b != '0));
                neg_r <= sgn && a[WIDTH-1];
              end
              default: done <= 1'b1;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            if (cnt == CNT_LAST) begin
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              lo <= quo;
              hi <= rem;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit at WIDTH=32 with hand sequences
// for flush, idle-flush blocking and asynchronous reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int errors;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op starting now (just after an edge), wait for done, check results.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    int exp_lat;
    exp_lat = o[2] ? 0 : W + 1;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, W'(busy), W'(o[2] ? 0 : 1));
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(exp_lat));
    chk({tag, "_busy_at_done"}, W'(busy), W'(0));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    flush = 1'b0;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{OP_DIVU,  32'h0001_3227, 32'h0000_A664, 32'h0000_8BC3, 32'h0000_0001};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{OP_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIVU,  32'h0000_5678, 32'h0000_0000, 32'h0000_5678, 32'hFFFF_FFFF};
    vecs[7]  = '{OP_DIV,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_MTHI,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vecs[9]  = '{OP_MTLO,  32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[10] = '{3'b110,   32'h0000_0001, 32'h0000_0001, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[11] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[12] = '{OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006};
    vecs[13] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[14] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[15] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[16] = '{3'b111,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[17] = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ops run back to back: each new request is presented during the previous done cycle.
    for (int i = 0; i < 18; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end
    @(posedge clk);
    #1;
    chk("done_single_pulse", W'(done), W'(0));

    // Flush mid-MULTU: HI/LO must keep the MTHI/MTLO values.
    do_op("pre_mthi", OP_MTHI, 32'hAAAA_5555, '0, 32'hAAAA_5555, 32'h0000_0000);
    do_op("pre_mtlo", OP_MTLO, 32'h5A5A_5A5A, '0, 32'hAAAA_5555, 32'h5A5A_5A5A);
    in_valid = 1'b1;
    op = OP_MULTU;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", W'(in_ready), W'(1));
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_done", W'(done), W'(0));
    chk("flush_hi", hi, 32'hAAAA_5555);
    chk("flush_lo", lo, 32'h5A5A_5A5A);
    do_op("post_flush", OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);

    // Flush in IDLE blocks the accept.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op = OP_MTHI;
    a = 32'h0BAD_F00D;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_done", W'(done), W'(0));
    chk("idle_flush_hi", hi, 32'h0000_0000);
    chk("idle_flush_busy", W'(busy), W'(0));

    // Asynchronous reset mid-DIV.
    in_valid = 1'b1;
    op = OP_DIV;
    a = 32'h7FFF_FFFF;
    b = 32'h0000_0003;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", W'(busy), W'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_hi", hi, '0);
    chk("async_reset_lo", lo, '0);
    chk("async_reset_busy", W'(busy), W'(0));
    chk("async_reset_in_ready", W'(in_ready), W'(1));
    chk("async_reset_done", W'(done), W'(0));
    #2;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) seen++;
      end
      chk("no_done_after_reset", W'(seen), W'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
